// File: rtl/evg_multi_sequencer.sv
// evg_multi_sequencer: multi-bank {gap, code} event sequencer streaming event codes on AXI-stream.
// Optional replay support is enabled by defining EVG_SEQ_REPEAT_EN.
module evg_multi_sequencer #(
  parameter int SEQUENCE_RAM_CAPACITY = 2048,
  parameter int BANK_COUNT = 4,
  parameter int EVENTCODE_WIDTH = 8,
  parameter int GAP_WIDTH = 28,
  parameter int REPEAT_WIDTH = 8,
  parameter logic [EVENTCODE_WIDTH-1:0] END_CODE = 'h7F,
  localparam int AW = $clog2(SEQUENCE_RAM_CAPACITY),
  localparam int BW = $clog2(BANK_COUNT),
  localparam int DW = GAP_WIDTH + EVENTCODE_WIDTH
) (
  input  logic                       evgTxClk,
  input  logic                       evgTxResetN,
  input  logic                       cfgWrEnable,
  input  logic [BW+AW-1:0]           cfgWrAddress,
  input  logic [DW-1:0]              cfgWrData,
  input  logic [BANK_COUNT-1:0]      cfgArm,
  input  logic [BANK_COUNT-1:0]      cfgDisarm,
  input  logic [REPEAT_WIDTH-1:0]    cfgRepeatCount,
  input  logic [EVENTCODE_WIDTH-1:0] cfgPrecompletionEvent,
  input  logic                       cfgAbort,
  input  logic                       evgSequenceStart,
  output logic [EVENTCODE_WIDTH-1:0] evgSequenceEventTDATA,
  output logic                       evgSequenceEventTVALID,
  input  logic                       evgSequenceEventTREADY,
  output logic [BANK_COUNT-1:0]      armed,
  output logic                       active,
  output logic                       busy,
  output logic [BW-1:0]              activeBank,
  output logic [REPEAT_WIDTH-1:0]    repeatRemaining,
  output logic [7:0]                 startsAccepted,
  output logic [7:0]                 startsIgnored
);
`ifdef EVG_SEQ_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif
  typedef enum logic [2:0] {S_IDLE, S_FETCH0, S_FETCH1, S_COUNT, S_EMIT, S_END} state_t;
  state_t state_q, state_d, ld_state;
  logic [DW-1:0] mem [BANK_COUNT*SEQUENCE_RAM_CAPACITY];
  logic [DW-1:0] rdata_q;
  logic [BANK_COUNT-1:0] armed_q, armed_d, clr;
  logic [BW-1:0] bank_q, bank_d, sel;
  logic [AW-1:0] ptr_q, ptr_d, raddr;
  logic [GAP_WIDTH:0] cnt_q, cnt_d;
  logic [EVENTCODE_WIDTH-1:0] code_q, code_d, ld_code;
  logic [GAP_WIDTH-1:0] ld_gap;
  logic [REPEAT_WIDTH-1:0] rep_q, rep_d;
  logic [7:0] acc_q, acc_d, ign_q, ign_d;
  logic busy_q, busy_d, abort_q, abort_d, abort, start_ok, re;
  always_comb begin
    sel = '0;
    for (int i = 0; i < BANK_COUNT; i++) if (armed_q[i]) sel = BW'(i);
    start_ok = evgSequenceStart && state_q == S_IDLE && |armed_q;
    abort = cfgAbort | abort_q;
    {ld_gap, ld_code} = rdata_q;
    ld_state = ld_gap != '0 ? S_COUNT : ld_code == END_CODE ? S_END : S_EMIT;
    state_d = state_q;
    bank_d = bank_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    code_d = code_q;
    busy_d = busy_q;
    rep_d = rep_q;
    abort_d = abort_q;
    clr = '0;
    re = 1'b0;
    raddr = '0;
    case (state_q)
      S_IDLE: if (start_ok) begin
        state_d = S_FETCH0;
        bank_d = sel;
        clr = sel != '0 ? BANK_COUNT'(1) << sel : '0;
        rep_d = REP_EN ? cfgRepeatCount : '0;
        busy_d = 1'b1;
      end
      S_FETCH0: begin
        re = 1'b1;
        state_d = cfgAbort ? S_IDLE : S_FETCH1;
      end
      S_FETCH1: begin
        re = 1'b1;
        raddr = AW'(1);
        ptr_d = '0;
        cnt_d = {1'b0, ld_gap};
        code_d = ld_code;
        state_d = cfgAbort ? S_IDLE : ld_state;
      end
      S_COUNT: begin
        cnt_d = cnt_q - 1'b1;
        state_d = cfgAbort ? S_IDLE : cnt_q != 1 ? S_COUNT : code_q == END_CODE ? S_END : S_EMIT;
      end
      S_EMIT: begin
        abort_d = abort;
        if (evgSequenceEventTREADY) begin
          busy_d = code_q == cfgPrecompletionEvent ? 1'b0 : busy_q;
          if (abort) state_d = S_IDLE;
          else if (ptr_q == '1) state_d = S_END;
          else begin
            re = 1'b1;
            raddr = ptr_q + AW'(2);
            ptr_d = ptr_q + 1'b1;
            cnt_d = {1'b0, ld_gap};
            code_d = ld_code;
            state_d = ld_state;
          end
        end
      end
      S_END: if (!cfgAbort && rep_q != '0) begin
        rep_d = rep_q - 1'b1;
        state_d = S_FETCH0;
      end else state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_IDLE) begin
      busy_d = 1'b0;
      abort_d = 1'b0;
    end
    armed_d = ((armed_q & ~clr) | cfgArm) & ~cfgDisarm;
    acc_d = acc_q + 8'(start_ok && acc_q != 8'hFF);
    ign_d = ign_q + 8'(evgSequenceStart && state_q != S_IDLE && ign_q != 8'hFF);
  end
  always_ff @(posedge evgTxClk) if (cfgWrEnable) mem[cfgWrAddress] <= cfgWrData;
  always_ff @(posedge evgTxClk or negedge evgTxResetN)
    if (!evgTxResetN) begin
      state_q <= S_IDLE;
      rdata_q <= '0;
      armed_q <= '0;
      bank_q <= '0;
      ptr_q <= '0;
      cnt_q <= '0;
      code_q <= '0;
      busy_q <= 1'b0;
      rep_q <= '0;
      abort_q <= 1'b0;
      acc_q <= '0;
      ign_q <= '0;
    end else begin
      state_q <= state_d;
      if (re) rdata_q <= mem[{bank_q, raddr}];
      armed_q <= armed_d;
      bank_q <= bank_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      code_q <= code_d;
      busy_q <= busy_d;
      rep_q <= rep_d;
      abort_q <= abort_d;
      acc_q <= acc_d;
      ign_q <= ign_d;
    end
  assign evgSequenceEventTDATA = code_q;
  assign evgSequenceEventTVALID = state_q == S_EMIT;
  assign armed = armed_q;
  assign active = state_q != S_IDLE;
  assign busy = busy_q;
  assign activeBank = bank_q;
  assign repeatRemaining = rep_q;
  assign startsAccepted = acc_q;
  assign startsIgnored = ign_q;
endmodule
